// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage.
// FSM encoding, byte-enable and register constants, alignment helper.
package mem_wb_stage_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic misaligned(
    input logic       is_byte,
    input logic [1:0] lane
  );
    return !is_byte && (lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_byte_lane_align.sv
// Byte-lane steering between the 32-bit datapath and memory.
// Lane select drives byte enables, sb replication and lb extraction.
module byte_lane_align
  import mem_wb_stage_pkg::*;
(
  input  logic        byte_acc,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    if (byte_acc) begin
      be        = 4'b0001 << lane;
      wdata     = {4{store_data[7:0]}};
      load_data = {24'b0, rdata[{lane, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory handshake, EX stall and the
// register-file write port.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_byte,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  output logic              stall,
  output logic              mem_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              RegWrite,
  output logic [4:0]        RegWr_ID,
  output logic [31:0]       Write_data,
  output logic              Load_Byte_control
);

  localparam int CW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          ld_q, byte_q, rw_q;
  logic [1:0]    lane_q;
  logic [4:0]    rd_q;

  logic          accept, is_mem, bad, start;
  logic          done, tout;
  logic          acc_byte;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata, load_data;

  assign stall  = (state == S_ACCESS);
  assign accept = ex_valid && !stall;
  assign is_mem = ex_mem_read || ex_mem_write;
  assign bad    = misaligned(ex_byte, ex_alu_result[1:0]);
  assign start  = accept && is_mem && !bad;
  assign done   = stall && dm_ack;
  assign tout   = stall && !dm_ack && TO_EN
                  && (cnt == T_LAST);

  // Request fields come from EX; load return uses the saved lane.
  assign acc_byte = stall ? byte_q : ex_byte;
  assign lane     = stall ? lane_q : ex_alu_result[1:0];

  byte_lane_align u_align (
    .byte_acc   (acc_byte),
    .lane       (lane),
    .store_data (ex_store_data),
    .rdata      (dm_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      start:        state_nxt = S_ACCESS;
      done || tout: state_nxt = S_IDLE;
      default:      state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt               <= '0;
      ld_q              <= 1'b0;
      byte_q            <= 1'b0;
      rw_q              <= 1'b0;
      lane_q            <= 2'b00;
      rd_q              <= REG_ZERO;
      mem_err           <= 1'b0;
      dm_req            <= 1'b0;
      dm_we             <= 1'b0;
      dm_addr           <= '0;
      dm_be             <= 4'h0;
      dm_wdata          <= 32'h0;
      RegWrite          <= 1'b0;
      RegWr_ID          <= REG_ZERO;
      Write_data        <= 32'h0;
      Load_Byte_control <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      if (accept && !is_mem && ex_reg_write
          && ex_rd != REG_ZERO) begin
        RegWrite          <= 1'b1;
        RegWr_ID          <= ex_rd;
        Write_data        <= ex_alu_result;
        Load_Byte_control <= 1'b0;
      end
      if (accept && is_mem && bad) mem_err <= 1'b1;
      if (start) begin
        dm_req   <= 1'b1;
        dm_we    <= !ex_mem_read;
        dm_addr  <= ex_alu_result[ADDR_W-1:2];
        dm_be    <= be;
        dm_wdata <= wdata;
        ld_q     <= ex_mem_read;
        byte_q   <= ex_byte;
        lane_q   <= ex_alu_result[1:0];
        rw_q     <= ex_reg_write;
        rd_q     <= ex_rd;
        cnt      <= '0;
      end
      if (stall) cnt <= cnt + 1'b1;
      if (done || tout) dm_req <= 1'b0;
      if (tout) mem_err <= 1'b1;
      if (done && ld_q && rw_q && rd_q != REG_ZERO) begin
        RegWrite          <= 1'b1;
        RegWr_ID          <= rd_q;
        Write_data        <= load_data;
        Load_Byte_control <= byte_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus random traffic
// against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_byte;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        stall, mem_err, dm_req, dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        RegWrite;
  logic [4:0]  RegWr_ID;
  logic [31:0] Write_data;
  logic        Load_Byte_control;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_byte(ex_byte),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .stall(stall), .mem_err(mem_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .RegWrite(RegWrite), .RegWr_ID(RegWr_ID),
    .Write_data(Write_data),
    .Load_Byte_control(Load_Byte_control)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding memory op, counted in cycles.
  bit          m_busy, m_load, m_byte, m_rw;
  int          m_k, m_lane;
  logic [4:0]  m_rd;
  logic [31:0] e_req, e_err, e_we, e_addr, e_be, e_wdata;
  logic [31:0] e_rw, e_id, e_wd, e_lbc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_k = 0; m_load = 0; m_byte = 0;
      m_rw = 0; m_lane = 0; m_rd = 0;
      e_req = 0; e_err = 0; e_we = 0; e_addr = 0;
      e_be = 0; e_wdata = 0; e_rw = 0; e_id = 0;
      e_wd = 0; e_lbc = 0;
    end else begin
      e_rw = 0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (!(ex_mem_read || ex_mem_write)) begin
            if (ex_reg_write && ex_rd != 0) begin
              e_rw = 1; e_id = 32'(ex_rd);
              e_wd = ex_alu_result; e_lbc = 0;
            end
          end else if (!ex_byte && ex_alu_result % 4 != 0) begin
            e_err = 1;
          end else begin
            m_busy = 1; m_k = 0;
            m_load = ex_mem_read;
            m_byte = ex_byte;
            m_rw = ex_reg_write;
            m_rd = ex_rd;
            m_lane = int'(ex_alu_result % 4);
            e_we = m_load ? 0 : 1;
            e_addr = ex_alu_result / 4;
            e_be = m_byte ? (32'd1 << m_lane) : 32'hF;
            e_wdata = m_byte
              ? (ex_store_data & 32'hFF) * 32'h01010101
              : ex_store_data;
          end
        end
      end else begin
        m_k++;
        if (dm_ack) begin
          m_busy = 0;
          if (m_load && m_rw && m_rd != 0) begin
            e_rw = 1; e_id = 32'(m_rd);
            e_wd = m_byte
              ? (dm_rdata >> (8 * m_lane)) & 32'hFF
              : dm_rdata;
            e_lbc = m_byte ? 1 : 0;
          end
        end else if (m_k == TO) begin
          m_busy = 0;
          e_err = 1;
        end
      end
      e_req = m_busy ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", 32'(stall), e_req);
      chk("dm_req", 32'(dm_req), e_req);
      chk("mem_err", 32'(mem_err), e_err);
      chk("RegWrite", 32'(RegWrite), e_rw);
      chk("RegWr_ID", 32'(RegWr_ID), e_id);
      chk("Write_data", Write_data, e_wd);
      chk("LBC", 32'(Load_Byte_control), e_lbc);
      if (e_req != 0) begin
        chk("dm_we", 32'(dm_we), e_we);
        chk("dm_addr", 32'(dm_addr), e_addr);
        chk("dm_be", 32'(dm_be), e_be);
        chk("dm_wdata", dm_wdata, e_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rd_, input logic wr_,
                        input logic by, input logic rw,
                        input logic [4:0] rd,
                        input logic [31:0] alu,
                        input logic [31:0] sd);
    ex_valid = 1'b1; ex_mem_read = rd_; ex_mem_write = wr_;
    ex_byte = by; ex_reg_write = rw; ex_rd = rd;
    ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  initial begin
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_byte = 0; ex_reg_write = 0; ex_rd = 0;
    ex_alu_result = 0; ex_store_data = 0;
    dm_rdata = 0; dm_ack = 0;
    repeat (2) tick();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_wd", Write_data, 32'd0);
    chk("rst_be", 32'(dm_be), 32'd0);
    rst_n = 1'b1;
    tick();

    // non-memory writeback
    set_ex(0, 0, 0, 1, 5'd8, 32'h0A12, 0);
    tick(); idle();
    chk("t1_rw", 32'(RegWrite), 32'd1);
    chk("t1_id", 32'(RegWr_ID), 32'd8);
    chk("t1_wd", Write_data, 32'h0A12);
    chk("t1_req", 32'(dm_req), 32'd0);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_pulse", 32'(RegWrite), 32'd0);
    chk("t1_hold", Write_data, 32'h0A12);

    // lw with three-cycle latency
    set_ex(1, 0, 0, 1, 5'd5, 32'h40, 0);
    tick(); idle();
    chk("t2_req", 32'(dm_req), 32'd1);
    chk("t2_addr", 32'(dm_addr), 32'h10);
    chk("t2_be", 32'(dm_be), 32'hF);
    chk("t2_we", 32'(dm_we), 32'd0);
    tick(); tick();
    chk("t2_stall", 32'(stall), 32'd1);
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    tick(); dm_ack = 0;
    chk("t2_stall_end", 32'(stall), 32'd0);
    chk("t2_rw", 32'(RegWrite), 32'd1);
    chk("t2_wd", Write_data, 32'hDEADBEEF);
    chk("t2_lbc", 32'(Load_Byte_control), 32'd0);

    // sb then lb
    set_ex(0, 1, 1, 0, 5'd2, 32'h43, 32'h000000FF);
    tick(); idle();
    chk("t3_be", 32'(dm_be), 32'h8);
    chk("t3_wdata", dm_wdata, 32'hFFFFFFFF);
    chk("t3_we", 32'(dm_we), 32'd1);
    dm_ack = 1; tick(); dm_ack = 0;
    chk("t3_norw", 32'(RegWrite), 32'd0);
    set_ex(1, 0, 1, 1, 5'd9, 32'h41, 0);
    tick(); idle();
    chk("t3_lb_be", 32'(dm_be), 32'h2);
    dm_ack = 1; dm_rdata = 32'h11223344;
    tick(); dm_ack = 0;
    chk("t3_lb_wd", Write_data, 32'h33);
    chk("t3_lb_lbc", 32'(Load_Byte_control), 32'd1);

    // misaligned lw, then load to r0
    set_ex(1, 0, 0, 1, 5'd6, 32'h42, 0);
    tick(); idle();
    chk("t4_req", 32'(dm_req), 32'd0);
    chk("t4_err", 32'(mem_err), 32'd1);
    chk("t4_rw", 32'(RegWrite), 32'd0);
    set_ex(1, 0, 0, 1, 5'd0, 32'h44, 0);
    tick(); idle();
    chk("t4_r0_req", 32'(dm_req), 32'd1);
    dm_ack = 1; tick(); dm_ack = 0;
    chk("t4_r0_rw", 32'(RegWrite), 32'd0);
    chk("t4_r0_hold", Write_data, 32'h33);

    rst_n = 0; tick();
    chk("rst_err_clr", 32'(mem_err), 32'd0);
    rst_n = 1; tick();

    // timeout with TIMEOUT=4
    set_ex(1, 0, 0, 1, 5'd3, 32'h80, 0);
    tick(); idle();
    repeat (3) tick();
    chk("t5_req_held", 32'(dm_req), 32'd1);
    tick();
    chk("t5_req_drop", 32'(dm_req), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_err", 32'(mem_err), 32'd1);
    chk("t5_rw", 32'(RegWrite), 32'd0);
    dm_ack = 1; dm_rdata = 32'h5555AAAA;
    tick(); dm_ack = 0;
    chk("t5_late_ack", 32'(RegWrite), 32'd0);

    // async reset mid-access
    set_ex(1, 0, 0, 1, 5'd4, 32'h100, 0);
    tick(); idle();
    chk("t6_req", 32'(dm_req), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("t6_req_rst", 32'(dm_req), 32'd0);
    chk("t6_stall_rst", 32'(stall), 32'd0);
    tick();
    rst_n = 1;
    set_ex(0, 0, 0, 1, 5'd7, 32'h77, 0);
    tick(); idle();
    chk("t6_rw", 32'(RegWrite), 32'd1);
    chk("t6_wd", Write_data, 32'h77);
    chk("t6_id", 32'(RegWr_ID), 32'd7);

    // random traffic
    repeat (3000) begin
      rst_n = ($urandom % 250 == 0) ? 1'b0 : 1'b1;
      ex_valid = ($urandom % 4) != 0;
      ex_mem_read = 1'($urandom);
      ex_mem_write = 1'($urandom);
      ex_byte = 1'($urandom);
      ex_reg_write = ($urandom % 4) != 0;
      ex_rd = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom);
      ex_alu_result = $urandom;
      if (!ex_byte && $urandom % 3 != 0)
        ex_alu_result[1:0] = 2'b00;
      ex_store_data = ex_byte ? {24'b0, 8'($urandom)}
                              : $urandom;
      dm_ack = ($urandom % 3) == 0;
      dm_rdata = $urandom;
      tick();
    end
    rst_n = 1; idle(); dm_ack = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
